servant_gpio_uart: RTL and testbench

- Downstream consumer of the servant SoC GPIO output port (gpio_clk plus gpio_out).
- On every rising edge of the gpio strobe, captures the 32-bit GPIO word into a FIFO.
- Transmits each captured word over a TX-only 8N1 UART as 8 uppercase ASCII hex digits (MSB nibble first) followed by LF (0x0A).
- Gives simulation and board a human-readable trace of every value software writes to GPIO, without stalling the CPU.

---
 rtl/servant_gpio_uart.sv | 149 ++++++++++++++
 tb/tb_servant_gpio_uart.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servant_gpio_uart.sv
// Captures each rising GPIO strobe into a FIFO and prints the word as 8 hex digits + LF on an 8N1 UART.
// Latency: capture cycle C -> start bit from cycle C+2 when idle; one word = 90*CLKS_PER_BIT cycles.
// Backpressure: none toward the CPU; a strobe arriving with the FIFO full is dropped and flagged sticky.
module servant_gpio_uart #(
    parameter int CLKS_PER_BIT = 139,
    parameter int DEPTH        = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_gpio_clk,
    input  logic [31:0]              i_gpio,
    output logic                     o_tx,
    output logic                     o_busy,
    output logic                     o_overflow,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL      = (AW+1)'(DEPTH);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [15:0]   baud_cnt, baud_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [3:0]    char_idx, char_nxt;
    logic [31:0]   word, word_nxt;
    logic          prev;
    logic          capture, push_rdy, push_ok;
    logic          pop_vld, pop_rdy, pop_ok;
    logic [31:0]   pop_dat;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   mem [DEPTH];
    logic [3:0]    nib;
    logic [7:0]    char_byte;
    logic          baud_end;
    logic          tx;

    assign capture  = i_gpio_clk & ~prev;
    assign push_rdy = (o_level != FULL);
    assign push_ok  = capture & push_rdy;
    assign pop_vld  = (o_level != '0);
    assign pop_ok   = pop_rdy & pop_vld;
    assign pop_dat  = mem[rd_ptr];

    // Room is judged on start-of-cycle occupancy, so a same-cycle pop never admits a push when full.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_level    <= '0;
            prev       <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            prev <= i_gpio_clk;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            o_level <= o_level + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
            if (capture && !push_rdy) o_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr] <= i_gpio;
    end

    // The shift word moves one nibble left per character, so the current digit is always word[31:28].
    assign nib       = word[31:28];
    assign char_byte = (char_idx == 4'd8) ? 8'h0A :
                       (nib < 4'd10)      ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    assign baud_end  = (baud_cnt == BAUD_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            char_idx <= '0;
            word     <= '0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            char_idx <= char_nxt;
            word     <= word_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        char_nxt  = char_idx;
        word_nxt  = word;
        pop_rdy   = 1'b0;
        tx        = 1'b1;
        case (state)
            IDLE: begin
                if (pop_vld) begin
                    pop_rdy   = 1'b1;
                    word_nxt  = pop_dat;
                    char_nxt  = '0;
                    baud_nxt  = '0;
                    state_nxt = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (baud_end) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = DATA;
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                tx = char_byte[bit_idx];
                if (baud_end) begin
                    baud_nxt = '0;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                    else                 bit_nxt   = bit_idx + 3'd1;
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_nxt = '0;
                    if (char_idx == 4'd8) begin
                        state_nxt = IDLE;
                    end else begin
                        char_nxt  = char_idx + 4'd1;
                        word_nxt  = {word[27:0], 4'h0};
                        state_nxt = START;
                    end
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_tx   = tx;
    assign o_busy = (state != IDLE) | (o_level != '0);

endmodule

// File: tb/tb_servant_gpio_uart.sv
// Bench for servant_gpio_uart: per-cycle reference model of the FIFO and UART line, plus a UART decoder.
module tb_servant_gpio_uart;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 9 * 10 * CPB;

    logic clk = 1'b0;
    logic rst, gclk;
    logic [31:0] gpio;
    logic tx, busy, ovf;
    logic [$clog2(DEPTH):0] level;

    always #5 clk = ~clk;

    servant_gpio_uart #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_gpio_clk(gclk), .i_gpio(gpio),
        .o_tx(tx), .o_busy(busy), .o_overflow(ovf), .o_level(level)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // reference model state
    logic [31:0] mq[$];
    logic [7:0]  exq[$];
    int          free_at, fstart;
    string       cur_line;
    bit          m_ovf, m_prev;
    // decoder state
    string       rx_log;
    bit          rx_on;
    int          rx_cnt;
    logic [7:0]  rx_sh;

    typedef struct {
        logic [31:0] w;
        string       line;
    } vec_t;
    vec_t tbl[6];

    function automatic string hexline(input logic [31:0] w);
        string s;
        logic [3:0] n;
        s = "";
        for (int i = 0; i < 8; i++) begin
            n = w[31-4*i -: 4];
            s = {s, $sformatf("%c", (n < 4'd10) ? (8'd48 + 8'(n)) : (8'd55 + 8'(n)))};
        end
        return {s, "\n"};
    endfunction

    function automatic string vis(input string s);
        string r;
        r = "";
        for (int i = 0; i < s.len(); i++)
            r = (s[i] == 8'h0A) ? {r, "\\n"} : {r, $sformatf("%c", s[i])};
        return r;
    endfunction

    function automatic logic exp_tx(input int k);
        int off, b;
        logic [7:0] c;
        if (k < fstart || k >= fstart + FRAME) return 1'b1;
        off = k - fstart;
        b   = (off % (10 * CPB)) / CPB;
        c   = cur_line[off / (10 * CPB)];
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return c[b-1];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\", required \"%s\"", name, vis(act), vis(exp));
        end
    endtask

    task automatic compare();
        check("tx", {31'd0, tx}, {31'd0, exp_tx(cyc)});
        check("level", 32'(level), 32'(mq.size()));
        check("busy", {31'd0, busy},
              {31'd0, (cyc >= fstart && cyc < fstart + FRAME) || mq.size() > 0});
        check("overflow", {31'd0, ovf}, {31'd0, m_ovf});
    endtask

    // Samples the line once per cycle; mid-bit sampling of each 8N1 frame.
    task automatic decode();
        int idx;
        if (!rx_on) begin
            if (tx === 1'b0) begin
                rx_on  = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
                idx = rx_cnt / CPB;
                if (idx >= 1 && idx <= 8) begin
                    rx_sh[idx-1] = tx;
                end else if (idx == 9) begin
                    check("stop_bit", {31'd0, tx}, 32'd1);
                    rx_log = {rx_log, $sformatf("%c", rx_sh)};
                    if (exq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_char: got %0h, required no character", rx_sh);
                    end else begin
                        check("rx_char", 32'(rx_sh), 32'(exq.pop_front()));
                    end
                    rx_on = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input logic g, input logic [31:0] v);
        bit cap, pop_now, push_ok;
        rst  = 1'b0;
        gclk = g;
        gpio = v;
        cap     = g && !m_prev;
        pop_now = (mq.size() > 0) && (cyc >= free_at);
        push_ok = cap && (mq.size() < DEPTH);
        @(posedge clk);
        #1;
        if (pop_now) begin
            cur_line = hexline(mq.pop_front());
            fstart   = cyc + 1;
            free_at  = cyc + 1 + FRAME;
            for (int i = 0; i < 9; i++) exq.push_back(cur_line[i]);
        end
        if (push_ok) mq.push_back(v);
        if (cap && !push_ok) m_ovf = 1'b1;
        m_prev = g;
        cyc++;
        compare();
        decode();
    endtask

    task automatic do_reset(input logic g);
        rst  = 1'b1;
        gclk = g;
        gpio = '0;
        @(posedge clk);
        #1;
        mq.delete();
        exq.delete();
        free_at = 0;
        fstart  = -100000;
        m_ovf   = 1'b0;
        m_prev  = 1'b0;
        rx_on   = 1'b0;
        cyc++;
        compare();
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_level", 32'(level), 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overflow", {31'd0, ovf}, 32'd0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 5000) begin
            step(1'b0, '0);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got busy after %0d cycles, required idle", n);
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0);
    endtask

    initial begin
        int n, maxlvl, c0;
        tbl[0].w = 32'h1234ABCD; tbl[0].line = "1234ABCD\n";
        tbl[1].w = 32'h00000000; tbl[1].line = "00000000\n";
        tbl[2].w = 32'hFFFFFFFF; tbl[2].line = "FFFFFFFF\n";
        tbl[3].w = 32'hDEADBEEF; tbl[3].line = "DEADBEEF\n";
        tbl[4].w = 32'h01234567; tbl[4].line = "01234567\n";
        tbl[5].w = 32'h89ABCDEF; tbl[5].line = "89ABCDEF\n";

        rst = 1'b1; gclk = 1'b0; gpio = '0;
        rx_log = ""; rx_on = 1'b0; rx_cnt = 0; rx_sh = '0;
        free_at = 0; fstart = -100000; m_ovf = 1'b0; m_prev = 1'b0;
        @(posedge clk);
        #1;
        do_reset(1'b0);
        do_reset(1'b1);

        // single words: start-bit latency, frame length, decoded text
        foreach (tbl[i]) begin
            rx_log = "";
            step(1'b1, tbl[i].w);
            check("tx_c1", {31'd0, tx}, 32'd1);
            step(1'b0, '0);
            check("tx_c2", {31'd0, tx}, 32'd0);
            n = 0;
            while (busy && n < 2000) begin
                step(1'b0, '0);
                n++;
            end
            check("frame_len", 32'(n), 32'(FRAME));
            for (int k = 0; k < 4; k++) step(1'b0, '0);
            check_str("line", rx_log, tbl[i].line);
        end

        // strobe held high captures once
        rx_log = "";
        maxlvl = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 32'h0);
            if (int'(level) > maxlvl) maxlvl = int'(level);
        end
        check("held_max_level", 32'(maxlvl), 32'd1);
        wait_idle();
        check_str("held_line", rx_log, "00000000\n");

        // overflow: 7 strobes every 2 cycles into a 4-deep FIFO
        rx_log = "";
        for (int v = 1; v <= 7; v++) begin
            step(1'b1, 32'(v));
            step(1'b0, 32'(v));
        end
        check("ovf_level", 32'(level), 32'd4);
        check("ovf_flag", {31'd0, ovf}, 32'd1);
        wait_idle();
        check("ovf_sticky", {31'd0, ovf}, 32'd1);
        check_str("ovf_lines", rx_log, "00000001\n00000002\n00000003\n00000004\n00000005\n");
        do_reset(1'b0);

        // back-to-back words (gap checked cycle by cycle against the model)
        rx_log = "";
        step(1'b1, 32'hFFFFFFFF);
        step(1'b0, '0);
        for (int i = 0; i < 100; i++) step(1'b0, '0);
        step(1'b1, 32'h9A000000);
        step(1'b0, '0);
        wait_idle();
        check_str("b2b_lines", rx_log, "FFFFFFFF\n9A000000\n");

        // reset in the middle of char 3 data bits with two words queued
        rx_log = "";
        c0 = cyc;
        step(1'b1, 32'h11111111); step(1'b0, '0);
        step(1'b1, 32'h22222222); step(1'b0, '0);
        step(1'b1, 32'h33333333); step(1'b0, '0);
        while (cyc < c0 + 132) step(1'b0, '0);
        check("queued", 32'(level), 32'd2);
        check_str("pre_rst_chars", rx_log, "111");
        do_reset(1'b0);
        rx_log = "";
        for (int i = 0; i < 500; i++) step(1'b0, '0);
        check_str("post_rst_silent", rx_log, "");
        step(1'b1, 32'h0000000F);
        step(1'b0, '0);
        wait_idle();
        check_str("post_rst_line", rx_log, "0000000F\n");

        // randomized: sparse then dense strobes
        do_reset(1'b0);
        for (int i = 0; i < 3000; i++) step($urandom_range(0, 299) == 0, $urandom);
        do_reset(1'b1);
        for (int i = 0; i < 1500; i++) step($urandom_range(0, 3) == 0, $urandom);
        wait_idle();
        check("rand_drained", 32'(exq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
